// File: rtl/uart_apb_loopback.sv
// APB3 slave with a baud generator and an 8N1 UART whose TX line is looped
// back internally into its own receiver, used as a bus-side UART self-test.
module uart_apb_loopback #(
  parameter int WIDTH    = 32,
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] PADDR,
  input  logic [WIDTH-1:0] PWDATA,
  output logic [WIDTH-1:0] PRDATA,
  output logic             PREADY
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  localparam logic [1:0] A_IDLE = 2'd0, A_SETUP = 2'd1, A_ACCESS = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  logic [1:0]    apb_st, tx_st, rx_st;
  logic          tx_en, rx_en;
  logic          tx_busy, rx_busy, rx_valid, frame_err;
  logic          tx_line, line_q;
  logic [7:0]    tx_buf, rx_shift, rx_data;
  logic [3:0]    tx_idx;
  logic [2:0]    rx_idx;
  logic [CW-1:0] bcnt, rcnt;
  logic          bclk, wr, rd_first, rx_clr, tx_load;
  logic          unused_bits;

  assign unused_bits = ^{PADDR[WIDTH-1:2], PWDATA[WIDTH-1:8]};
  assign PREADY   = 1'b1;
  assign wr       = PSEL & PENABLE & PWRITE;
  // only the first ACCESS cycle of a read may consume rx_valid
  assign rd_first = PSEL & PENABLE & ~PWRITE & (apb_st != A_ACCESS);
  assign rx_clr   = rd_first & (PADDR[1:0] == 2'd3);
  assign tx_load  = wr & (PADDR[1:0] == 2'd2) & tx_en & ~tx_busy;
  assign bclk     = (bcnt == DIV_M1);

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR[1:0])
        2'd0: begin PRDATA[0] = tx_en; PRDATA[3] = rx_en; end
        2'd1: PRDATA[3:0] = {frame_err, rx_valid, rx_busy, tx_busy};
        2'd3: PRDATA[7:0] = rx_data;
        default: PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      apb_st <= A_IDLE;
      tx_en  <= 1'b0;
      rx_en  <= 1'b0;
      bcnt   <= '0;
    end else begin
      if (!PSEL)        apb_st <= A_IDLE;
      else if (PENABLE) apb_st <= A_ACCESS;
      else              apb_st <= A_SETUP;
      if (wr && PADDR[1:0] == 2'd0) begin
        tx_en <= PWDATA[0];
        rx_en <= PWDATA[3];
      end
      bcnt <= bclk ? '0 : bcnt + 1'b1;
    end
  end

  // TX: START waits for the next BCLK to launch the start bit, so every
  // line transition stays aligned to BCLK regardless of when the write lands.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_st   <= S_IDLE;
      tx_busy <= 1'b0;
      tx_line <= 1'b1;
      tx_buf  <= '0;
      tx_idx  <= '0;
    end else begin
      case (tx_st)
        S_IDLE: if (tx_load) begin
          tx_buf  <= PWDATA[7:0];
          tx_busy <= 1'b1;
          tx_st   <= S_START;
        end
        S_START: if (bclk) begin
          tx_line <= 1'b0;
          tx_idx  <= '0;
          tx_st   <= S_DATA;
        end
        S_DATA: if (bclk) begin
          if (tx_idx == 4'd8) begin
            tx_line <= 1'b1;
            tx_st   <= S_STOP;
          end else begin
            tx_line <= tx_buf[tx_idx[2:0]];
            tx_idx  <= tx_idx + 1'b1;
          end
        end
        default: if (bclk) begin
          tx_busy <= 1'b0;
          tx_st   <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_st     <= S_IDLE;
      rx_busy   <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
      rx_shift  <= '0;
      rx_idx    <= '0;
      rcnt      <= '0;
      line_q    <= 1'b1;
    end else begin
      line_q <= tx_line;
      if (rx_clr) rx_valid <= 1'b0;
      if (!rx_en) begin
        rx_st   <= S_IDLE;
        rx_busy <= 1'b0;
      end else begin
        case (rx_st)
          S_IDLE: if (line_q && !tx_line) begin
            rcnt    <= '0;
            rx_busy <= 1'b1;
            rx_st   <= S_START;
          end
          S_START: if (rcnt == HALF_M1) begin
            rcnt <= '0;
            if (tx_line) begin
              rx_busy <= 1'b0;
              rx_st   <= S_IDLE;
            end else begin
              rx_idx <= '0;
              rx_st  <= S_DATA;
            end
          end else rcnt <= rcnt + 1'b1;
          S_DATA: if (rcnt == DIV_M1) begin
            rcnt     <= '0;
            rx_shift <= {tx_line, rx_shift[7:1]};
            rx_idx   <= rx_idx + 1'b1;
            if (rx_idx == 3'd7) rx_st <= S_STOP;
          end else rcnt <= rcnt + 1'b1;
          default: if (rcnt == DIV_M1) begin
            // setting rx_valid here overrides a same-cycle read-clear
            rx_data   <= rx_shift;
            rx_valid  <= 1'b1;
            frame_err <= ~tx_line;
            rx_busy   <= 1'b0;
            rx_st     <= S_IDLE;
          end else rcnt <= rcnt + 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_apb_loopback.sv
// Directed bench for uart_apb_loopback: stimulus queues expected read data,
// a separate monitor compares PRDATA whenever a read access completes.
module tb_uart_apb_loopback;
  localparam int DIV = 16;

  logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA, rv;
  logic        PREADY;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  uart_apb_loopback #(.WIDTH(32), .CLK_FREQ(1600), .BAUD(100)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // read-data monitor: one queue entry per completed read access
  always @(negedge PCLK) begin
    if (PSEL && PENABLE && !PWRITE) begin
      if (q.size() == 0) begin
        check("unexpected_read", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.mask != 0) begin
          check(e.name, PRDATA & e.mask, e.exp);
          check({e.name, "_pready"}, {31'b0, PREADY}, 32'h1);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge PCLK);
  endtask

  task automatic apb_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 32'h4000_1000 | {30'b0, a}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [1:0] a, input logic [31:0] exp, input logic [31:0] mask,
                        input string nm, output logic [31:0] got);
    exp_t e;
    e.exp = exp; e.mask = mask; e.name = nm;
    q.push_back(e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 32'hFFFF_F000 | {30'b0, a};
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    got = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] g;
    apb_rd(a, exp, 32'hFFFF_FFFF, nm, g);
  endtask

  initial begin
    bit seen;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    cyc(3); #2;
    check("reset_tx_line", {31'b0, dut.tx_line}, 32'h1);
    PRESETn = 1'b1;

    // 1: reset state on all addresses
    rd(2'd0, 32'h0, "rst_ctrl");
    rd(2'd1, 32'h0, "rst_status");
    rd(2'd2, 32'h0, "rst_txdata");
    rd(2'd3, 32'h0, "rst_rxdata");

    // 2: control register
    apb_wr(2'd0, 32'hFFFF_FFF9);
    rd(2'd0, 32'h9, "ctrl_rb");
    rd(2'd1, 32'h0, "status_idle");

    // 3: first loopback frame
    apb_wr(2'd2, 32'h0000_00A0);
    rd(2'd2, 32'h0, "txdata_reads0");
    seen = 1'b0;
    for (int i = 0; i < 2 * DIV && !seen; i++) begin
      apb_rd(2'd1, 32'h0, 32'h0, "poll", rv);
      if (rv[1:0] == 2'b11) seen = 1'b1;
    end
    check("both_busy_seen", {31'b0, seen}, 32'h1);
    cyc(12 * DIV);
    rd(2'd1, 32'h4, "status_valid_a0");
    rd(2'd3, 32'hA0, "rxdata_a0");
    rd(2'd1, 32'h0, "status_cleared");

    // 4: tx disabled, write ignored
    apb_wr(2'd0, 32'h0);
    apb_wr(2'd2, 32'h55);
    rd(2'd1, 32'h0, "txoff_not_busy");
    cyc(12 * DIV);
    rd(2'd1, 32'h0, "txoff_no_valid");
    rd(2'd3, 32'hA0, "txoff_rx_kept");

    // 5: write while busy dropped
    apb_wr(2'd0, 32'h9);
    apb_wr(2'd2, 32'h3C);
    apb_wr(2'd2, 32'hFF);
    cyc(12 * DIV);
    rd(2'd1, 32'h4, "status_valid_3c");
    rd(2'd3, 32'h3C, "rxdata_3c");

    // receiver disabled: no rx activity, data held
    apb_wr(2'd0, 32'h1);
    apb_wr(2'd2, 32'h77);
    rd(2'd1, 32'h1, "rxoff_tx_only");
    cyc(12 * DIV);
    rd(2'd1, 32'h0, "rxoff_status");
    rd(2'd3, 32'h3C, "rxoff_rx_kept");

    // 6: reset mid-frame, then a clean frame
    apb_wr(2'd0, 32'h9);
    apb_wr(2'd2, 32'hA5);
    cyc(3 * DIV);
    #3 PRESETn = 1'b0;
    #1 check("midreset_tx_line", {31'b0, dut.tx_line}, 32'h1);
    cyc(2); #2 PRESETn = 1'b1;
    rd(2'd1, 32'h0, "postreset_status");
    rd(2'd0, 32'h0, "postreset_ctrl");
    rd(2'd3, 32'h0, "postreset_rxdata");
    apb_wr(2'd0, 32'h9);
    apb_wr(2'd2, 32'h5A);
    cyc(12 * DIV);
    rd(2'd1, 32'h4, "status_valid_5a");
    rd(2'd3, 32'h5A, "rxdata_5a");

    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1);
    if (q.size() != 0) check("queue_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
